global_avg_pool: RTL
====================

GLOBAL_AVG_POOL -- requirements
Module: global_avg_pool

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, the number of channels per frame.
REQ-002 SHALL have parameter ACT_PER_ADDR, default 4, the pixels per SRAM address.
REQ-003 SHALL have parameter BW_PER_ACT, default 12, the signed bits per pixel.
REQ-004 SHALL have parameter BEATS_LOG2, default 2, where a channel window is 2**BEATS_LOG2 beats of 4 addresses each (64 pixels at default).
REQ-005 SHALL have ports: clk input 1 clock; srst_n input 1 synchronous active-low reset.
REQ-006 SHALL have ports: in_valid input 1; in_ready output 1; in_data input 4*ACT_PER_ADDR*BW_PER_ACT, 16 signed pixels with the pixel at the MSB first.
REQ-007 SHALL have port pool_mode input 1, where 0 = average and 1 = max.
REQ-008 SHALL have ports: out_valid output 1; out_ready input 1; out_data output ACT_PER_ADDR*BW_PER_ACT; out_ch output clog2(CH_NUM); frame_done output 1.

Function
REQ-009 SHALL implement a two-state FSM: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-010 SHALL count accepted beats only on in_valid&&in_ready, using a beat counter of width BEATS_LOG2 that wraps to 0 after the last beat.
REQ-011 SHALL, on the first beat of a channel, sample pool_mode and hold it for that channel; pool_mode changes mid-channel SHALL be ignored.
REQ-012 SHALL, in average mode, sum the 16 pixels of each beat with sign extension and accumulate into a signed accumulator of BW_PER_ACT+4+BEATS_LOG2 bits; the first beat SHALL load the accumulator rather than add to it.
REQ-013 SHALL compute the average result as (acc + 2**(S-1)) >>> S, where S = 4+BEATS_LOG2: round half toward +inf, arithmetic shift, result truncated to BW_PER_ACT bits (always in range, no clamp needed).
REQ-014 SHALL, in max mode, compute the signed maximum of the 16 beat pixels and the running max; the first beat SHALL load the beat max directly.
REQ-015 SHALL transition ACC->HOLD in the cycle after the last beat handshake, with out_data registered: result in the top BW_PER_ACT bits and the remaining lanes 0.
REQ-016 SHALL hold out_data and out_ch stable in HOLD while out_ready=0.
REQ-017 SHALL, on out_valid&&out_ready, return to ACC and increment out_ch, wrapping CH_NUM-1->0.
REQ-018 SHALL pulse frame_done for exactly one cycle, coincident with the output handshake of channel CH_NUM-1.
REQ-019 SHALL give a channel latency of last-beat handshake to out_valid of 1 cycle and a minimum of 2**BEATS_LOG2+1 cycles per channel.
REQ-020 SHALL ignore in_data and in_valid while in HOLD.

Reset
REQ-021 SHALL, on srst_n=0 at a clk edge, set: state ACC, beat counter 0, out_ch 0, accumulator 0, out_data 0, out_valid 0, frame_done 0, latched mode 0.
REQ-022 SHALL, on reset mid-channel or in HOLD, discard partial results and restart at channel 0 with no output emitted.

Structure
REQ-023 SHALL place the FSM state encoding and the derived widths (S, accumulator width) in a shared package, pool_pkg.
REQ-024 SHALL use one sub-module, beat_reduce: combinational 16-pixel signed sum and max.

Verification
REQ-025 Avg basic: all pixels 64 for 4 beats -> out_data top lane 64, out_ch 0.
REQ-026 Rounding: one pixel +32, rest 0 -> 1; one pixel -32, rest 0 -> 0; one pixel -33, rest 0 -> -1.
REQ-027 Max mode: beat 2 has one pixel 2047, all others -2048 -> 2047; all pixels -5 -> -5.
REQ-028 Backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, no beats lost; in_valid gaps do not change the result.
REQ-029 Frame: 4 channels with constant values 1, 2, 3, 4 -> outputs in order with out_ch 0..3, frame_done on the 4th handshake only, then out_ch back to 0.
REQ-030 Reset: srst_n=0 after 2 beats, then 4 beats of value 10 -> single output 10 on channel 0.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared FSM encoding and derived widths for global_avg_pool.
package pool_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // 16 pixels per beat -> 4 extra sum bits per beat
  localparam int LANE_LOG2 = 4;

  function automatic int shift_w(input int beats_log2);
    return LANE_LOG2 + beats_log2;
  endfunction

  function automatic int acc_w(input int bw_per_act, input int beats_log2);
    return bw_per_act + LANE_LOG2 + beats_log2;
  endfunction

endpackage

// File: rtl/global_avg_pool_beat_reduce.sv
// Combinational signed sum and signed maximum of the pixels of one input beat.
module beat_reduce #(
  parameter int NPIX  = 16,
  parameter int BW    = 12,
  parameter int SUM_W = BW + 4
) (
  input  logic [NPIX*BW-1:0]       data,
  output logic signed [SUM_W-1:0]  beat_sum,
  output logic signed [BW-1:0]     beat_max
);

  logic signed [BW-1:0] px;

  always_comb begin
    px       = '0;
    beat_sum = '0;
    beat_max = data[NPIX*BW-1 -: BW];
    for (int i = 0; i < NPIX; i++) begin
      px       = data[i*BW +: BW];
      beat_sum = beat_sum + {{(SUM_W-BW){px[BW-1]}}, px};
      if (px > beat_max) beat_max = px;
    end
  end

endmodule

// File: rtl/global_avg_pool.sv
// Per-channel global average / max pooling over a window of beats, one result per channel.
//   state   | meaning
//   ST_ACC  | accepting beats, accumulating sum or running max
//   ST_HOLD | result presented on out_data, waiting for out_ready
module global_avg_pool
  import pool_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 12,
  parameter int BEATS_LOG2   = 2
) (
  input  logic                                  clk,
  input  logic                                  srst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [4*ACT_PER_ADDR*BW_PER_ACT-1:0]  in_data,
  input  logic                                  pool_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ACT_PER_ADDR*BW_PER_ACT-1:0]    out_data,
  output logic [$clog2(CH_NUM)-1:0]             out_ch,
  output logic                                  frame_done
);

  localparam int NPIX  = 4 * ACT_PER_ADDR;
  localparam int BW    = BW_PER_ACT;
  localparam int S     = shift_w(BEATS_LOG2);
  localparam int ACC_W = acc_w(BW_PER_ACT, BEATS_LOG2);
  localparam int SUM_W = BW + LANE_LOG2;
  localparam int OUT_W = ACT_PER_ADDR * BW;
  localparam int CH_W  = $clog2(CH_NUM);
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1 << (S - 1));

  state_t                  state;
  logic [BEATS_LOG2-1:0]   beat_cnt;
  logic                    mode_q;
  logic signed [ACC_W-1:0] acc;

  logic signed [SUM_W-1:0] beat_sum;
  logic signed [BW-1:0]    beat_max;
  logic signed [ACC_W-1:0] sum_ext, max_ext, acc_next, rounded;
  logic [BW-1:0]           result;
  logic                    first_beat, last_beat, mode_eff, in_fire, out_fire, last_ch;

  beat_reduce #(
    .NPIX  (NPIX),
    .BW    (BW),
    .SUM_W (SUM_W)
  ) u_beat_reduce (
    .data     (in_data),
    .beat_sum (beat_sum),
    .beat_max (beat_max)
  );

  assign in_ready   = (state == ST_ACC);
  assign out_valid  = (state == ST_HOLD);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = &beat_cnt;
  assign last_ch    = (out_ch == CH_W'(CH_NUM - 1));
  assign frame_done = out_fire && last_ch;
  // Mode is taken live on the first beat, then frozen for the rest of the channel
  assign mode_eff   = first_beat ? pool_mode : mode_q;

  assign sum_ext = {{(ACC_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
  assign max_ext = {{(ACC_W-BW){beat_max[BW-1]}}, beat_max};

  always_comb begin
    acc_next = acc;
    if (mode_eff) acc_next = (first_beat || (max_ext > acc)) ? max_ext : acc;
    else          acc_next = first_beat ? sum_ext : (acc + sum_ext);
  end

  // Round half toward +inf; the shifted value always fits in BW bits
  assign rounded = acc_next + ROUND;
  assign result  = mode_eff ? acc_next[BW-1:0] : BW'(rounded >>> S);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state    <= ST_ACC;
      beat_cnt <= '0;
      mode_q   <= 1'b0;
      acc      <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_fire) begin
            beat_cnt <= beat_cnt + BEATS_LOG2'(1);
            acc      <= acc_next;
            if (first_beat) mode_q <= pool_mode;
            if (last_beat) begin
              out_data <= {result, {(OUT_W-BW){1'b0}}};
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state  <= ST_ACC;
            out_ch <= last_ch ? '0 : out_ch + CH_W'(1);
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
